serial_parity_rx: RTL and testbench
===================================

Name: serial_parity_rx

Overview:
- Serial frame receiver with a parity checker; it is the sequential consumer of the team's XOR parity logic.
- Takes a qualified serial bit stream, one bit per enabled cycle. Frame format: start(0), DATA_W data bits LSB-first, one parity bit, stop(1).
- Accumulates the XOR of the data bits and checks it against the received parity bit.
- Presents the parallel word with a one-cycle valid strobe plus parity and framing error flags.

Parameters:
- DATA_W, 8, number of data bits per frame. Legal range is 2 to 32.
- ODD_PARITY, 0. 0 selects even parity (parity bit = XOR of data bits). 1 selects odd parity (parity bit = ~XOR of data bits).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bit_in  input  1  serial data bit; sampled only when bit_valid=1.
- bit_valid  input  1  qualifies bit_in for this cycle. When low, all state holds.
- data_out  output  DATA_W  last received data word. Held until the next frame completes.
- data_valid  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  1 when the received parity bit mismatched on the last completed frame.
- frame_err  output  1  1 when the stop bit was 0 on the last completed frame.
- busy  output  1  1 when the FSM is in any state other than IDLE.

Behaviour:
- Reset: clk and rst_n is one clock domain. Reset is asynchronous, active-low.
  - rst_n=0 forces: state=IDLE, bit counter=0, shift reg=0, parity accumulator=0.
  - rst_n=0 also forces outputs: data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
  - Asserting reset mid-frame discards the partial frame silently; no valid pulse is produced.
- FSM states and transitions (all on rising clk with bit_valid=1; bit_valid=0 holds every register except data_valid):
  - IDLE: bit_in=1 is ignored (line idle). bit_in=0 is a start bit: go to DATA, clear counter and accumulator.
  - DATA: shift bit_in into the MSB of the shift reg (LSB-first reception). accumulator <= accumulator ^ bit_in. Counter increments. After the DATA_W-th data bit, go to PARITY.
  - PARITY: compute expected = accumulator ^ ODD_PARITY. Register mismatch = (bit_in != expected). Go to STOP.
  - STOP: on the same edge, data_out <= shift reg, parity_err <= mismatch, frame_err <= ~bit_in, data_valid <= 1. Go to IDLE.
  - A 0 stop bit is not treated as the next start bit.
- data_valid rules:
  - High for exactly one cycle following the stop-bit sampling edge, then 0.
  - It is 0 whenever no stop bit was sampled on the previous edge, including while bit_valid=0.
- Error flags and data_out are registered with data_valid and hold until the next frame completes or reset.
- A frame with frame_err=1 still updates data_out and pulses data_valid.
- Latency: data_valid rises on the edge that samples the stop bit, so it is visible 1 clk after that bit is presented.
- Counter width is clog2(DATA_W)+1. The counter never wraps inside a frame.
- busy=1 in DATA, PARITY and STOP. A new start bit may arrive on the very next valid cycle after STOP, giving back-to-back frames with no idle bits.

Test Plan:
- DATA_W=8, even parity, send 0 | 1,0,1,0,0,1,0,1 | 0 | 1 with bit_valid held high -> data_out=0xA5, one-cycle data_valid, parity_err=0, frame_err=0, busy low after the stop bit.
- Send 0x01 with parity bit 0 (expected 1) and stop 1 -> data_out=0x01, data_valid pulse, parity_err=1, frame_err=0. A following correct frame of 0x03 with parity 0 -> parity_err returns to 0.
- Send 0x3C with correct parity 0 and stop bit 0 -> data_out=0x3C, frame_err=1, parity_err=0. FSM is in IDLE and the next 1s are ignored with no new start.
- Frame 0xA5 with bit_valid deasserted for 3 random cycles between each bit -> same result as the first scenario. State, counter and outputs are stable during the gaps, and exactly one data_valid pulse is produced.
- Pull rst_n low asynchronously mid-clock after 4 data bits -> outputs immediately 0 and busy=0. After release, a full 0x5A frame with parity 0 -> data_out=0x5A with no corruption from the aborted frame.
- ODD_PARITY=1: frame 0xFF with parity bit 1, then two back-to-back frames 0x00/parity 1 and 0x80/parity 0 -> three data_valid pulses, all error flags 0.
- ODD_PARITY=1, 0x80 with parity 1 -> parity_err=1.

Source files
------------

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB-first, parity, stop(1).
// Presents the received word with a one-cycle valid strobe plus parity/framing error flags.
module serial_parity_rx #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  shift_reg;
  logic               par_acc;
  logic               par_mismatch;

  // Frame FSM; every register holds on cycles without bit_valid except the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      par_acc      <= 1'b0;
      par_mismatch <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (bit_valid) begin
        case (state)
          IDLE: begin
            if (!bit_in) begin
              state   <= DATA;
              bit_cnt <= '0;
              par_acc <= 1'b0;
              busy    <= 1'b1;
            end
          end
          DATA: begin
            // LSB arrives first, so after DATA_W shifts it sits in bit 0
            shift_reg <= {bit_in, shift_reg[DATA_W-1:1]};
            par_acc   <= par_acc ^ bit_in;
            bit_cnt   <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_mismatch <= bit_in ^ (par_acc ^ ODD_PARITY);
            state        <= STOP;
          end
          STOP: begin
            // A low stop bit is flagged only; it never doubles as a start bit
            data_out   <= shift_reg;
            parity_err <= par_mismatch;
            frame_err  <= ~bit_in;
            data_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: even- and odd-parity instances share one bit stream;
// table-driven directed frames, an async mid-frame reset, then random frames vs a frame-level model.
module tb_serial_parity_rx;

  localparam int unsigned DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              bit_in;
  logic              bit_valid;
  logic [DATA_W-1:0] data_out_e, data_out_o;
  logic              dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

  serial_parity_rx #(.DATA_W(DATA_W), .ODD_PARITY(1'b0)) dut_e (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(data_out_e), .data_valid(dv_e), .parity_err(pe_e),
    .frame_err(fe_e), .busy(busy_e)
  );

  serial_parity_rx #(.DATA_W(DATA_W), .ODD_PARITY(1'b1)) dut_o (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(data_out_o), .data_valid(dv_o), .parity_err(pe_o),
    .frame_err(fe_o), .busy(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Expected held outputs (shared data/frame flag, per-instance parity flag)
  logic [DATA_W-1:0] exp_data;
  logic              exp_pe_e, exp_pe_o, exp_fe, exp_busy;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         gap;
    int         idle;
    logic       pe_even;
    logic       pe_odd;
    logic       fe;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic dv);
    chk({tag, " data_out even"}, 32'(data_out_e), 32'(exp_data));
    chk({tag, " data_out odd"},  32'(data_out_o), 32'(exp_data));
    chk({tag, " data_valid even"}, 32'(dv_e), 32'(dv));
    chk({tag, " data_valid odd"},  32'(dv_o), 32'(dv));
    chk({tag, " parity_err even"}, 32'(pe_e), 32'(exp_pe_e));
    chk({tag, " parity_err odd"},  32'(pe_o), 32'(exp_pe_o));
    chk({tag, " frame_err even"},  32'(fe_e), 32'(exp_fe));
    chk({tag, " frame_err odd"},   32'(fe_o), 32'(exp_fe));
    chk({tag, " busy even"}, 32'(busy_e), 32'(exp_busy));
    chk({tag, " busy odd"},  32'(busy_o), 32'(exp_busy));
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge
  task automatic step(input logic b, input logic v);
    @(negedge clk);
    bit_in    = b;
    bit_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input string tag, input logic [7:0] d, input logic p, input logic s,
                            input int gap, input int idle,
                            input logic pe_even, input logic pe_odd, input logic fe);
    logic bits [11];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9]  = p;
    bits[10] = s;
    repeat (idle) begin
      step(1'b1, 1'b1);
      exp_busy = 1'b0;
      check_all({tag, " idle"}, 1'b0);
    end
    for (int k = 0; k < 11; k++) begin
      if (k > 0) begin
        repeat (gap) begin
          step(1'($urandom), 1'b0);
          check_all({tag, " gap"}, 1'b0);
        end
      end
      step(bits[k], 1'b1);
      if (k < 10) begin
        exp_busy = 1'b1;
        check_all({tag, " bit"}, 1'b0);
      end else begin
        exp_data = d;
        exp_pe_e = pe_even;
        exp_pe_o = pe_odd;
        exp_fe   = fe;
        exp_busy = 1'b0;
        check_all({tag, " done"}, 1'b1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              data   par   stop  gap idle pe_e  pe_o  fe
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 0, 2, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{8'h01, 1'b0, 1'b1, 0, 1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h03, 1'b0, 1'b1, 0, 1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h3C, 1'b0, 1'b0, 0, 1, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{8'hA5, 1'b0, 1'b1, 3, 3, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'h5A, 1'b0, 1'b1, 0, 1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{8'hFF, 1'b1, 1'b1, 0, 2, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{8'h00, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{8'h80, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{8'h80, 1'b1, 1'b1, 0, 2, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; bit_in = 1'b1; bit_valid = 1'b0;
    exp_data = '0; exp_pe_e = 1'b0; exp_pe_o = 1'b0; exp_fe = 1'b0; exp_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      send_frame($sformatf("tbl%0d", i), tbl[i].data, tbl[i].par, tbl[i].stop, tbl[i].gap,
                 tbl[i].idle, tbl[i].pe_even, tbl[i].pe_odd, tbl[i].fe);
    end

    // Mid-frame async reset after a start bit and four data bits of 0x3C
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'(8'h3C >> i), 1'b1);
    bit_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_data = '0; exp_pe_e = 1'b0; exp_pe_o = 1'b0; exp_fe = 1'b0; exp_busy = 1'b0;
    check_all("async reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 5; i < 10; i++) begin
      send_frame($sformatf("tbl%0d", i), tbl[i].data, tbl[i].par, tbl[i].stop, tbl[i].gap,
                 tbl[i].idle, tbl[i].pe_even, tbl[i].pe_odd, tbl[i].fe);
    end

    // Random frames; expectations come from the frame contents alone
    for (int n = 0; n < 25; n++) begin
      logic [7:0] d;
      logic       p, s, xr;
      d  = 8'($urandom);
      p  = 1'($urandom);
      s  = ($urandom_range(0, 3) != 0);
      xr = ^d;
      send_frame($sformatf("rnd%0d", n), d, p, s, int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)), p != xr, p != ~xr, ~s);
    end

    step(1'b1, 1'b1);
    check_all("tail", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
